// File: rtl/card_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | card_pkg : flip FSM states and default board geometry shared with game   |
// | control.                                             Revision: 1.0       |
// +--------------------------------------------------------------------------+
package card_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHRINK = 2'd1,
        GROW   = 2'd2
    } flip_state_t;

    localparam int c_grid_cols = 4;
    localparam int c_grid_rows = 4;
    localparam int c_origin_x  = 130;
    localparam int c_origin_y  = 70;
    localparam int c_pitch_x   = 100;
    localparam int c_pitch_y   = 100;
    localparam int c_card_w    = 83;
    localparam int c_card_h    = 83;
    localparam int c_pix_bits  = 3;
    localparam int c_flip_log2 = 2;

endpackage
`default_nettype wire

// File: rtl/card_flip_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | card_flip_fsm : flip sequencer, squeeze counter k and face-up mask.      |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module card_flip_fsm
    import card_pkg::*;
#(
    parameter int NC        = 16,
    parameter int FLIP_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_frame_tick,
    input  logic                    i_flip_req,
    input  logic [$clog2(NC)-1:0]   i_flip_idx,
    input  logic                    i_clear_all,
    output logic                    o_flip_busy,
    output logic                    o_flip_done,
    output logic [NC-1:0]           o_face_up,
    output logic [$clog2(NC)-1:0]   o_anim_idx,
    output logic [FLIP_LOG2:0]      o_k
);

    localparam int c_kw = FLIP_LOG2 + 1;
    localparam logic [FLIP_LOG2:0] c_half    = c_kw'(1 << FLIP_LOG2);
    localparam logic [FLIP_LOG2:0] c_one     = c_kw'(1);
    localparam logic [FLIP_LOG2:0] c_half_m1 = c_kw'((1 << FLIP_LOG2) - 1);

    flip_state_t              r_state_q, w_state_d;
    logic [FLIP_LOG2:0]       r_k_q, w_k_d;
    logic [$clog2(NC)-1:0]    r_idx_q, w_idx_d;
    logic [NC-1:0]            r_face_q, w_face_d;
    logic                     r_busy_q, w_busy_d;
    logic                     r_done_q, w_done_d;

    always_comb begin
        w_state_d = r_state_q;
        w_k_d     = r_k_q;
        w_idx_d   = r_idx_q;
        w_face_d  = r_face_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        if (i_clear_all) begin
            w_state_d = IDLE;
            w_k_d     = c_half;
            w_face_d  = '0;
            w_busy_d  = 1'b0;
        end else begin
            case (r_state_q)
                // a frame_tick in the accept cycle is deliberately not counted
                IDLE: begin
                    w_k_d = c_half;
                    if (i_flip_req && (int'(i_flip_idx) < NC)) begin
                        w_idx_d   = i_flip_idx;
                        w_state_d = SHRINK;
                        w_busy_d  = 1'b1;
                    end
                end
                SHRINK: begin
                    if (i_frame_tick) begin
                        w_k_d = r_k_q - c_one;
                        if (r_k_q == c_one) begin
                            w_face_d[r_idx_q] = ~r_face_q[r_idx_q];
                            w_state_d         = GROW;
                        end
                    end
                end
                GROW: begin
                    if (i_frame_tick) begin
                        w_k_d = r_k_q + c_one;
                        if (r_k_q == c_half_m1) begin
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                            w_state_d = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_d = IDLE;
                    w_k_d     = c_half;
                    w_busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_k_q     <= c_half;
            r_idx_q   <= '0;
            r_face_q  <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_k_q     <= w_k_d;
            r_idx_q   <= w_idx_d;
            r_face_q  <= w_face_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_flip_busy = r_busy_q;
    assign o_flip_done = r_done_q;
    assign o_face_up   = r_face_q;
    assign o_anim_idx  = r_idx_q;
    assign o_k         = r_k_q;

endmodule
`default_nettype wire

// File: rtl/card_grid_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | card_grid_renderer : card grid hit test and 2-stage pixel pipeline with  |
// | flip squeeze.                                        Revision: 1.0       |
// +--------------------------------------------------------------------------+
module card_grid_renderer
    import card_pkg::*;
#(
    parameter int GRID_COLS  = c_grid_cols,
    parameter int GRID_ROWS  = c_grid_rows,
    parameter int ORIGIN_X   = c_origin_x,
    parameter int ORIGIN_Y   = c_origin_y,
    parameter int PITCH_X    = c_pitch_x,
    parameter int PITCH_Y    = c_pitch_y,
    parameter int CARD_W     = c_card_w,
    parameter int CARD_H     = c_card_h,
    parameter int PIX_BITS   = c_pix_bits,
    parameter int FLIP_LOG2  = c_flip_log2,
    parameter logic [PIX_BITS-1:0] BACK_RGB   = 3'b001,
    parameter logic [PIX_BITS-1:0] BORDER_RGB = 3'b111
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [9:0]                                 hcount,
    input  logic [9:0]                                 vcount,
    input  logic                                       frame_tick,
    input  logic                                       flip_req,
    input  logic [$clog2(GRID_COLS*GRID_ROWS)-1:0]     flip_idx,
    input  logic                                       clear_all,
    output logic                                       flip_busy,
    output logic                                       flip_done,
    output logic [GRID_COLS*GRID_ROWS-1:0]             face_up,
    output logic [$clog2(CARD_H)-1:0]                  rom_addr,
    input  logic [CARD_W*PIX_BITS-1:0]                 rom_data,
    output logic                                       cardon,
    output logic [PIX_BITS-1:0]                        rgb
);

    localparam int c_nc  = GRID_COLS * GRID_ROWS;
    localparam int c_iw  = $clog2(c_nc);
    localparam int c_xw  = $clog2(CARD_W);
    localparam int c_yw  = $clog2(CARD_H);
    localparam int c_mid = (CARD_W - 1) / 2;

    logic [c_iw-1:0]       w_anim_idx;
    logic [FLIP_LOG2:0]    w_k;

    card_flip_fsm #(
        .NC        (c_nc),
        .FLIP_LOG2 (FLIP_LOG2)
    ) u_flip_fsm (
        .clk          (clk),
        .rst          (reset),
        .i_frame_tick (frame_tick),
        .i_flip_req   (flip_req),
        .i_flip_idx   (flip_idx),
        .i_clear_all  (clear_all),
        .o_flip_busy  (flip_busy),
        .o_flip_done  (flip_done),
        .o_face_up    (face_up),
        .o_anim_idx   (w_anim_idx),
        .o_k          (w_k)
    );

    // Stage 1: hit test against every column and row window
    int                 w_col_i, w_row_i;
    logic               w_x_hit, w_y_hit;
    logic               r_hit_q, w_hit_d;
    logic [c_iw-1:0]    r_idx_q, w_idx_d;
    logic [c_xw-1:0]    r_lx_q, w_lx_d;
    logic [c_yw-1:0]    r_ly_q, w_ly_d;

    always_comb begin
        w_x_hit = 1'b0;
        w_y_hit = 1'b0;
        w_col_i = 0;
        w_row_i = 0;
        w_lx_d  = '0;
        w_ly_d  = '0;
        for (int c = 0; c < GRID_COLS; c++) begin
            if ((int'(hcount) >= ORIGIN_X + c * PITCH_X) &&
                (int'(hcount) <  ORIGIN_X + c * PITCH_X + CARD_W)) begin
                w_x_hit = 1'b1;
                w_col_i = c;
                w_lx_d  = c_xw'(int'(hcount) - ORIGIN_X - c * PITCH_X);
            end
        end
        for (int r = 0; r < GRID_ROWS; r++) begin
            if ((int'(vcount) >= ORIGIN_Y + r * PITCH_Y) &&
                (int'(vcount) <  ORIGIN_Y + r * PITCH_Y + CARD_H)) begin
                w_y_hit = 1'b1;
                w_row_i = r;
                w_ly_d  = c_yw'(int'(vcount) - ORIGIN_Y - r * PITCH_Y);
            end
        end
        w_hit_d = w_x_hit && w_y_hit;
        w_idx_d = c_iw'(w_row_i * GRID_COLS + w_col_i);
    end

    // Stage 2: squeeze crop around the card's centre column, then colour select
    int                 w_lx_i, w_ly_i, w_dx_i, w_lim_i;
    logic               w_squeeze, w_visible, w_border;
    logic               r_cardon_q, w_cardon_d;
    logic [PIX_BITS-1:0] r_rgb_q, w_rgb_d;

    always_comb begin
        w_lx_i     = int'(r_lx_q);
        w_ly_i     = int'(r_ly_q);
        w_dx_i     = (w_lx_i >= c_mid) ? (w_lx_i - c_mid) : (c_mid - w_lx_i);
        w_lim_i    = (c_mid * int'(w_k)) >> FLIP_LOG2;
        w_squeeze  = flip_busy && (r_idx_q == w_anim_idx);
        w_visible  = !w_squeeze || ((w_k != '0) && (w_dx_i <= w_lim_i));
        w_border   = (w_lx_i < 2) || (w_lx_i >= CARD_W - 2) ||
                     (w_ly_i < 2) || (w_ly_i >= CARD_H - 2);
        w_cardon_d = r_hit_q && w_visible;
        w_rgb_d    = '0;
        if (w_cardon_d) begin
            if (face_up[r_idx_q]) begin
                w_rgb_d = rom_data[w_lx_i * PIX_BITS +: PIX_BITS];
            end else if (w_border) begin
                w_rgb_d = BORDER_RGB;
            end else begin
                w_rgb_d = BACK_RGB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_q    <= 1'b0;
            r_idx_q    <= '0;
            r_lx_q     <= '0;
            r_ly_q     <= '0;
            r_cardon_q <= 1'b0;
            r_rgb_q    <= '0;
        end else begin
            r_hit_q    <= w_hit_d;
            r_idx_q    <= w_idx_d;
            r_lx_q     <= w_lx_d;
            r_ly_q     <= w_ly_d;
            r_cardon_q <= w_cardon_d;
            r_rgb_q    <= w_rgb_d;
        end
    end

    assign rom_addr = r_ly_q;
    assign cardon   = r_cardon_q;
    assign rgb      = r_rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_card_grid_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_card_grid_renderer : scoreboard bench for card_grid_renderer.         |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_card_grid_renderer;

    logic         clk;
    logic         reset;
    logic [9:0]   hcount, vcount;
    logic         frame_tick, flip_req, clear_all;
    logic [3:0]   flip_idx;
    logic         flip_busy, flip_done, cardon;
    logic [15:0]  face_up;
    logic [6:0]   rom_addr;
    logic [248:0] rom_data;
    logic [2:0]   rgb;

    int total = 0;
    int bad   = 0;
    int pix_n = 0;
    int flip_n = 0;

    logic tb_probe, probe_d1, probe_d2;
    logic       exp_on_q[$];
    logic [2:0] exp_rgb_q[$];
    int         id_q[$];
    int         done_q[$];

    card_grid_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_tick (frame_tick),
        .flip_req   (flip_req),
        .flip_idx   (flip_idx),
        .clear_all  (clear_all),
        .flip_busy  (flip_busy),
        .flip_done  (flip_done),
        .face_up    (face_up),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cardon     (cardon),
        .rgb        (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Face ROM: pixel lx of row a has colour (lx + a) mod 8
    always_comb begin
        rom_data = '0;
        for (int i = 0; i < 83; i++) begin
            rom_data[i*3 +: 3] = 3'((i + int'(rom_addr)) & 7);
        end
    end

    always @(posedge clk) begin
        probe_d1 <= tb_probe;
        probe_d2 <= probe_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pixel scoreboard two cycles after each probe, and flip_done pulses
    always @(negedge clk) begin
        if (probe_d2) begin
            total++;
            if (exp_on_q.size() == 0) begin
                bad++;
                $display("FAIL pix_unexpected: got cardon=%0b rgb=%0h expected none", cardon, rgb);
            end else begin
                automatic logic       e_on  = exp_on_q.pop_front();
                automatic logic [2:0] e_rgb = exp_rgb_q.pop_front();
                automatic int         e_id  = id_q.pop_front();
                if (cardon !== e_on || rgb !== e_rgb) begin
                    bad++;
                    $display("FAIL pix%0d: got cardon=%0b rgb=%0h expected cardon=%0b rgb=%0h",
                             e_id, cardon, rgb, e_on, e_rgb);
                end
            end
        end
        if (flip_done === 1'b1) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL flip_done_unexpected: got pulse expected none");
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic on, input logic [2:0] c,
                         input int addr);
        hcount   = 10'(x);
        vcount   = 10'(y);
        tb_probe = 1'b1;
        exp_on_q.push_back(on);
        exp_rgb_q.push_back(c);
        id_q.push_back(pix_n);
        pix_n++;
        @(negedge clk);
        tb_probe = 1'b0;
        hcount   = '0;
        vcount   = '0;
        if (addr >= 0) check("rom_addr", 32'(rom_addr), 32'(addr));
        @(negedge clk);
    endtask

    task automatic start_flip(input int idx, input logic with_tick);
        flip_req   = 1'b1;
        flip_idx   = 4'(idx);
        frame_tick = with_tick;
        @(negedge clk);
        flip_req   = 1'b0;
        frame_tick = 1'b0;
        check("busy_rise", 32'(flip_busy), 32'd1);
        done_q.push_back(flip_n);
        flip_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; flip_req = 1'b0; clear_all = 1'b0;
        flip_idx = '0; tb_probe = 1'b0; hcount = 10'd140; vcount = 10'd80;
        cyc(3);
        check("rst_cardon", 32'(cardon), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_face", 32'(face_up), 32'd0);
        check("rst_busy", 32'(flip_busy), 32'd0);
        check("rst_done", 32'(flip_done), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        hcount = '0; vcount = '0;
        cyc(1);

        // Face-down card 0: border, body, gap, far edge, off-screen
        probe(130, 70, 1'b1, 3'b111, 0);
        probe(140, 80, 1'b1, 3'b001, 10);
        probe(213, 70, 1'b0, 3'b000, -1);
        probe(212, 152, 1'b1, 3'b111, 82);
        probe(129, 70, 1'b0, 3'b000, -1);
        probe(640, 479, 1'b0, 3'b000, -1);

        // Flip card 5 with a coincident tick that must not count
        start_flip(5, 1'b1);
        for (int t = 1; t <= 8; t++) begin
            tick();
            check("busy_flip", 32'(flip_busy), (t < 8) ? 32'd1 : 32'd0);
            check("face5", 32'(face_up[5]), (t >= 4) ? 32'd1 : 32'd0);
            if (t == 2) begin
                probe(250, 200, 1'b0, 3'b000, 30);
                probe(251, 200, 1'b1, 3'b001, 30);
            end
            if (t == 4) probe(271, 211, 1'b0, 3'b000, 41);
        end
        cyc(1);
        check("busy_idle", 32'(flip_busy), 32'd0);
        probe(271, 211, 1'b1, 3'd2, 41);
        probe(232, 172, 1'b1, 3'd4, 2);

        // Request for card 3 while busy is dropped
        start_flip(0, 1'b0);
        tick();
        flip_req = 1'b1; flip_idx = 4'd3;
        @(negedge clk);
        flip_req = 1'b0;
        repeat (7) tick();
        cyc(2);
        check("face_ignore", 32'(face_up), 32'h0021);
        check("busy_ignore", 32'(flip_busy), 32'd0);

        // clear_all in GROW
        start_flip(2, 1'b0);
        repeat (5) tick();
        check("face_grow", 32'(face_up), 32'h0025);
        void'(done_q.pop_back());
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        check("face_clear", 32'(face_up), 32'h0000);
        check("busy_clear", 32'(flip_busy), 32'd0);
        repeat (4) tick();
        start_flip(7, 1'b0);
        repeat (8) tick();
        cyc(1);
        check("face_after_clear", 32'(face_up), 32'h0080);

        // reset in SHRINK
        start_flip(7, 1'b0);
        repeat (2) tick();
        void'(done_q.pop_back());
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("face_rst", 32'(face_up), 32'h0000);
        check("busy_rst", 32'(flip_busy), 32'd0);
        repeat (8) tick();
        start_flip(1, 1'b0);
        repeat (8) tick();
        cyc(1);
        check("face_after_rst", 32'(face_up), 32'h0002);

        // clear_all beats a simultaneous flip_req
        clear_all = 1'b1; flip_req = 1'b1; flip_idx = 4'd4;
        @(negedge clk);
        clear_all = 1'b0; flip_req = 1'b0;
        check("busy_clr_req", 32'(flip_busy), 32'd0);
        check("face_clr_req", 32'(face_up), 32'h0000);
        repeat (8) tick();
        check("face_clr_req_end", 32'(face_up), 32'h0000);

        cyc(4);
        check("done_pending", 32'(done_q.size()), 32'd0);
        check("pix_pending", 32'(exp_on_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
